spi_transaction_scheduler: RTL and testbench

Sequencer that sits between the AXI-side register/FIFO logic and the SP3A SPI controller. It pops 32-bit transaction descriptors from a descriptor FIFO, checks that the command buffer (writes) or read buffer (reads) can service the whole transfer, and drives the controller's `WnR`/`spi_address`/`spi_opcode_group`/`spi_data_len` inputs. It then waits for `done`, or aborts on a watchdog timeout, and enforces a minimum `cs_b`-high gap between transactions. It also keeps transaction and error status for software.

---
 rtl/spi_transaction_scheduler.sv | 173 +++++++++++++++++
 tb/tb_spi_transaction_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transaction_scheduler.sv
// spi_transaction_scheduler
//   Pops 32-bit descriptors from a first-word-fall-through FIFO, waits until
//   the SPI command buffer (writes) or read buffer (reads) can hold the whole
//   transfer, drives the SP3A controller inputs, then waits for done and
//   enforces an idle gap before the next descriptor. Keeps a completed
//   transaction count and a sticky timeout flag for software.
//
//   Optional feature macro: SPI_SCHED_TIMEOUT_EN
//     defined   -> WAIT_DONE watchdog; expiry aborts via ABORT and sets err_timeout
//     undefined -> no watchdog; WAIT_DONE exits only on done; err_timeout = 0
//
// Ports
//   axi_clk, reset_b        clock, async active-low reset
//   enable                  allows fetching new descriptors
//   clear_status            pulse: clears txn_count and err_timeout
//   desc_empty, desc_dout   descriptor FIFO head (FWFT)
//   desc_rd_en              FIFO pop strobe
//   cmd_count, read_space   command buffer fill / read buffer free space (words)
//   WnR, spi_address,
//   spi_opcode_group,
//   spi_data_len            controller inputs (spi_data_len != 0 starts, 0 aborts)
//   done                    controller completion pulse
//   busy                    high outside IDLE
//   txn_count               transactions completed via done (wraps)
//   err_timeout             sticky watchdog abort flag
module spi_transaction_scheduler #(
  parameter int          GAP_CYCLES     = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2048,
  parameter int          CNT_W          = 6
) (
  input  logic             axi_clk,
  input  logic             reset_b,
  input  logic             enable,
  input  logic             clear_status,
  input  logic             desc_empty,
  input  logic [31:0]      desc_dout,
  output logic             desc_rd_en,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [CNT_W-1:0] read_space,
  output logic             WnR,
  output logic [9:0]       spi_address,
  output logic [1:0]       spi_opcode_group,
  output logic [7:0]       spi_data_len,
  input  logic             done,
  output logic             busy,
  output logic [15:0]      txn_count,
  output logic             err_timeout
);

  // compare width wide enough for both the 9-bit word count and CNT_W
  localparam int AW = (CNT_W > 9) ? CNT_W : 9;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT_DONE, S_ABORT, S_GAP
  } state_t;

  state_t state, state_nxt;

  logic          d_wnr;
  logic [1:0]    d_grp;
  logic [9:0]    d_addr;
  logic [7:0]    d_len;
  logic [8:0]    words;
  logic          res_ok;
  logic          fetch;
  logic          txn_done;
  logic          wd_exp;
  logic          gap_last;
  logic [GW-1:0] gap_cnt;
  logic          unused_desc;

  // bits of the descriptor that carry no meaning here
  assign unused_desc = ^{desc_dout[30], desc_dout[27:26], desc_dout[15:8]};

  // 32-bit words needed for data_len bits; 255 -> 8 needs the 9th bit
  assign words    = ({1'b0, d_len} + 9'd31) >> 5;
  assign res_ok   = d_wnr ? (AW'(cmd_count)  >= AW'(words))
                          : (AW'(read_space) >= AW'(words));
  assign txn_done = (state == S_WAIT_DONE) && done;
  assign gap_last = (gap_cnt == GW'(GAP_CYCLES - 1));

  always_ff @(posedge axi_clk or negedge reset_b) begin
    if (!reset_b) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    case (state)
      S_IDLE:
        if (enable && !desc_empty) begin
          fetch     = 1'b1;
          state_nxt = S_CHECK;
        end
      S_CHECK:
        if (d_len == 8'd0) state_nxt = S_IDLE;
        else if (res_ok)   state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_DONE;
      // done takes priority over a coincident watchdog expiry
      S_WAIT_DONE:
        if (done)        state_nxt = S_GAP;
        else if (wd_exp) state_nxt = S_ABORT;
      S_ABORT:     state_nxt = S_GAP;
      S_GAP:
        if (gap_last) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge reset_b) begin
    if (!reset_b) begin
      desc_rd_en       <= 1'b0;
      busy             <= 1'b0;
      d_wnr            <= 1'b0;
      d_grp            <= '0;
      d_addr           <= '0;
      d_len            <= '0;
      WnR              <= 1'b0;
      spi_address      <= '0;
      spi_opcode_group <= '0;
      spi_data_len     <= '0;
      gap_cnt          <= '0;
      txn_count        <= '0;
    end else begin
      desc_rd_en <= fetch;
      busy       <= (state_nxt != S_IDLE);
      if (fetch) begin
        d_wnr  <= desc_dout[31];
        d_grp  <= desc_dout[29:28];
        d_addr <= desc_dout[25:16];
        d_len  <= desc_dout[7:0];
      end
      if (state == S_ISSUE) begin
        WnR              <= d_wnr;
        spi_address      <= d_addr;
        spi_opcode_group <= d_grp;
        spi_data_len     <= d_len;
      end else if (state == S_WAIT_DONE && (done || wd_exp)) begin
        // zero on the done edge so the controller never restarts from IDLE
        spi_data_len <= 8'd0;
      end
      gap_cnt <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
      if (clear_status)  txn_count <= '0;
      else if (txn_done) txn_count <= txn_count + 16'd1;
    end
  end

`ifdef SPI_SCHED_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign wd_exp = (wd_cnt == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge axi_clk or negedge reset_b) begin
    if (!reset_b) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      wd_cnt <= (state == S_WAIT_DONE) ? wd_cnt + 16'd1 : 16'd0;
      if (clear_status)          err_timeout <= 1'b0;
      else if (state == S_ABORT) err_timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_exp         = 1'b0;
  assign err_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_transaction_scheduler.sv
// Self-checking bench for spi_transaction_scheduler: reset values, a table of
// single descriptors with buffer levels, hand sequences for hold/discard/gap/
// timeout/reset, then a randomized run against a transaction-level model.
module tb_spi_transaction_scheduler;
  localparam int GAP = 4;
  localparam int CW  = 6;

  logic          axi_clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          enable = 1'b0, clear_status = 1'b0, desc_empty = 1'b1, done = 1'b0;
  logic [31:0]   desc_dout = '0;
  logic [CW-1:0] cmd_count = '0, read_space = '0;
  logic          desc_rd_en, WnR, busy, err_timeout;
  logic [9:0]    spi_address;
  logic [1:0]    spi_opcode_group;
  logic [7:0]    spi_data_len;
  logic [15:0]   txn_count;

  spi_transaction_scheduler #(
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(16'd8), .CNT_W(CW)
  ) dut (
    .axi_clk(axi_clk), .reset_b(reset_b), .enable(enable), .clear_status(clear_status),
    .desc_empty(desc_empty), .desc_dout(desc_dout), .desc_rd_en(desc_rd_en),
    .cmd_count(cmd_count), .read_space(read_space), .WnR(WnR),
    .spi_address(spi_address), .spi_opcode_group(spi_opcode_group),
    .spi_data_len(spi_data_len), .done(done), .busy(busy),
    .txn_count(txn_count), .err_timeout(err_timeout)
  );

  always #5 axi_clk = ~axi_clk;

  int          total = 0, bad = 0, exp_txn = 0;
  logic [31:0] fifo[$];
  bit          pop_pend = 0;

  typedef struct {
    bit w; logic [1:0] g; logic [9:0] a; logic [7:0] l;
    logic [CW-1:0] cmd; logic [CW-1:0] rs; bit go;
  } vec_t;
  vec_t tbl[9];

  // random-phase model state
  int          model_cnt, exp_rise, gap_at, zero_at, act_cnt, words, n_rd, zc;
  bit          chk_on, p_busy, p_done, p_clr, p_en, p_empty, ok;
  logic [7:0]  p_sdl, first;
  logic [31:0] chk_d, iss_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(bit w, logic [1:0] g, logic [9:0] a, logic [7:0] l);
    return {w, 1'b0, g, 2'b00, a, 8'h00, l};
  endfunction

  function automatic logic [31:0] rand_desc();
    logic [31:0] d;
    d = $urandom;
    case ($urandom % 9)
      0: d[7:0] = 8'd0;   1: d[7:0] = 8'd1;   2: d[7:0] = 8'd31;
      3: d[7:0] = 8'd32;  4: d[7:0] = 8'd33;  5: d[7:0] = 8'd64;
      6: d[7:0] = 8'd65;  7: d[7:0] = 8'd255;
      default: ;
    endcase
    return d;
  endfunction

  task automatic upd_fifo();
    desc_empty = (fifo.size() == 0);
    desc_dout  = desc_empty ? 32'h0 : fifo[0];
  endtask

  // advance one cycle; outputs are then stable for the new cycle
  task automatic tick();
    @(posedge axi_clk); #1;
    if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
    pop_pend = desc_rd_en;
    upd_fifo();
  endtask

  task automatic wait_rd(input string nm);
    bit f = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (desc_rd_en) begin f = 1; break; end end
    chk(nm, f, 1);
  endtask

  task automatic wait_nz(input string nm);
    bit f = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (spi_data_len != 0) begin f = 1; break; end end
    chk(nm, f, 1);
  endtask

  task automatic wait_idle(input string nm);
    bit f = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (!busy) begin f = 1; break; end end
    chk(nm, f, 1);
  endtask

  task automatic finish_txn(input string nm);
    done = 1; tick(); done = 0; exp_txn++;
    chk({nm, "_zero"}, spi_data_len, 0);
    chk({nm, "_cnt"}, txn_count, exp_txn);
    wait_idle({nm, "_idle"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    tbl[0] = '{1, 2'b01, 10'h05A, 8'd40,  6'd2,  6'd0,  1};
    tbl[1] = '{1, 2'b10, 10'h3FF, 8'd32,  6'd1,  6'd0,  1};
    tbl[2] = '{1, 2'b11, 10'h001, 8'd33,  6'd1,  6'd63, 0};
    tbl[3] = '{1, 2'b00, 10'h200, 8'd255, 6'd8,  6'd0,  1};
    tbl[4] = '{1, 2'b01, 10'h155, 8'd255, 6'd7,  6'd0,  0};
    tbl[5] = '{0, 2'b10, 10'h0AA, 8'd1,   6'd63, 6'd0,  0};
    tbl[6] = '{0, 2'b11, 10'h2AA, 8'd1,   6'd0,  6'd1,  1};
    tbl[7] = '{0, 2'b00, 10'h0F0, 8'd64,  6'd0,  6'd2,  1};
    tbl[8] = '{0, 2'b01, 10'h10F, 8'd65,  6'd5,  6'd2,  0};

    // reset values
    #3;
    chk("rst_ctl", {desc_rd_en, busy, err_timeout, WnR}, 0);
    chk("rst_spi", {spi_address, spi_opcode_group, spi_data_len}, 0);
    chk("rst_cnt", txn_count, 0);
    #10 reset_b = 1;
    enable = 1;
    tick();

    // single descriptors: issue exactly 2 cycles after the pop, or hold in CHECK
    foreach (tbl[i]) begin
      cmd_count = tbl[i].cmd; read_space = tbl[i].rs;
      fifo.push_back(mk(tbl[i].w, tbl[i].g, tbl[i].a, tbl[i].l)); upd_fifo();
      wait_rd("tbl_pop");
      tick(); tick();
      chk("tbl_len", spi_data_len, tbl[i].go ? 32'(tbl[i].l) : 32'd0);
      if (!tbl[i].go) begin
        chk("tbl_hold_busy", busy, 1);
        cmd_count = '1; read_space = '1;
        wait_nz("tbl_late");
        chk("tbl_late_len", spi_data_len, tbl[i].l);
      end
      chk("tbl_fields", {WnR, spi_opcode_group, spi_address}, {tbl[i].w, tbl[i].g, tbl[i].a});
      finish_txn("tbl");
    end

    // read held in CHECK until read_space covers 2 words
    cmd_count = 0; read_space = 1;
    fifo.push_back(mk(0, 2'b10, 10'h123, 8'd33)); upd_fifo();
    wait_rd("hold_pop");
    for (int i = 0; i < 4; i++) begin tick(); chk("hold_len", spi_data_len, 0); end
    chk("hold_busy", busy, 1);
    read_space = 2;
    tick(); chk("hold_issue", spi_data_len, 0);
    tick(); chk("hold_go", spi_data_len, 33);
    finish_txn("hold");

    // enable low blocks fetch; zero-length descriptor is discarded
    enable = 0; cmd_count = '1;
    fifo.push_back(mk(1, 2'b01, 10'h000, 8'd0));
    fifo.push_back(mk(1, 2'b11, 10'h2C3, 8'd8)); upd_fifo();
    n_rd = 0;
    for (int i = 0; i < 5; i++) begin tick(); n_rd += int'(desc_rd_en); end
    chk("en_block", n_rd, 0);
    enable = 1; n_rd = 0; first = 0;
    for (int i = 0; i < 30 && first == 0; i++) begin
      tick(); n_rd += int'(desc_rd_en); first = spi_data_len;
    end
    chk("z_pops", n_rd, 2);
    chk("z_first", first, 8);
    chk("z_addr", spi_address, 10'h2C3);
    chk("z_txn", txn_count, exp_txn);
    finish_txn("z");

    // back-to-back: zero cycles between done and next issue = GAP + IDLE + CHECK + ISSUE
    fifo.push_back(mk(1, 2'b01, 10'h011, 8'd16));
    fifo.push_back(mk(1, 2'b10, 10'h022, 8'd16)); upd_fifo();
    wait_nz("g1_go");
    done = 1; tick(); done = 0; exp_txn++;
    chk("g1_cnt", txn_count, exp_txn);
    zc = 0;
    for (int i = 0; i < 30 && spi_data_len == 0; i++) begin zc++; tick(); end
    chk("gap_len", zc, GAP + 3);
    chk("g2_addr", spi_address, 10'h022);
    // clear coinciding with an increment leaves zero
    clear_status = 1; done = 1; tick(); clear_status = 0; done = 0; exp_txn = 0;
    chk("clr_win", txn_count, 0);
    chk("clr_zero", spi_data_len, 0);
    wait_idle("clr_idle");

    // withheld done
    read_space = '1;
    fifo.push_back(mk(0, 2'b01, 10'h321, 8'd20)); upd_fifo();
    wait_nz("to_go");
`ifdef SPI_SCHED_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin tick(); chk("to_hold", spi_data_len, 20); end
    tick(); chk("to_abort", spi_data_len, 0); chk("to_err0", err_timeout, 0);
    tick(); chk("to_err", err_timeout, 1); chk("to_txn", txn_count, exp_txn);
    clear_status = 1; tick(); clear_status = 0;
    chk("to_clr", err_timeout, 0);
    wait_idle("to_idle");
`else
    for (int i = 0; i < 20; i++) begin tick(); chk("nto_hold", spi_data_len, 20); end
    chk("nto_err", err_timeout, 0);
    finish_txn("nto");
`endif

    // asynchronous reset during WAIT_DONE
    fifo.push_back(mk(1, 2'b11, 10'h3C3, 8'd200)); upd_fifo();
    wait_nz("rw_go");
    #2 reset_b = 0;
    #1;
    chk("rw_spi", {WnR, spi_address, spi_opcode_group, spi_data_len}, 0);
    chk("rw_ctl", {busy, desc_rd_en, err_timeout}, 0);
    chk("rw_cnt", txn_count, 0);
    exp_txn = 0;
    #1 reset_b = 1;
    n_rd = 0;
    for (int i = 0; i < 5; i++) begin tick(); n_rd += int'(desc_rd_en) + int'(busy); end
    chk("rw_quiet", n_rd, 0);
    fifo.push_back(mk(1, 2'b00, 10'h0C0, 8'd4)); upd_fifo();
    wait_rd("rw_refetch");
    wait_nz("rw_go2");
    finish_txn("rw");

    // randomized run against transaction-level rules
    #2 reset_b = 0;
    #2 reset_b = 1;
    model_cnt = 0; exp_rise = -1; gap_at = -1; zero_at = -1; act_cnt = 0; chk_on = 0;
    p_busy = 0; p_sdl = 0; p_done = 0; p_clr = 0; p_en = enable; p_empty = desc_empty;
    for (int c = 0; c < 3000; c++) begin
      tick();
      chk("r_pop", desc_rd_en, !p_busy && p_en && !p_empty);
      if (desc_rd_en) begin
        chk("r_pop_data", fifo.size() != 0, 1);
        if (fifo.size() != 0) begin chk_on = 1; chk_d = fifo[0]; end
      end
      if (p_done && p_sdl != 0) begin
        model_cnt++;
        chk("r_end", spi_data_len, 0);
        gap_at = c + GAP;
      end
      if (p_clr) model_cnt = 0;
      chk("r_txn", txn_count, model_cnt);
      if (c == gap_at)  chk("r_gap", {p_busy, busy}, 2'b10);
      if (c == zero_at) chk("r_zero_len", busy, 0);
      if (p_sdl != 0 && spi_data_len == 0) chk("r_fall_done", p_done, 1);
      if (p_sdl == 0 && spi_data_len != 0) begin
        chk("r_rise_t", c, exp_rise);
        chk("r_rise_d", {WnR, spi_opcode_group, spi_address, spi_data_len},
            {iss_d[31], iss_d[29:28], iss_d[25:16], iss_d[7:0]});
        exp_rise = -1;
      end else if (c == exp_rise) begin
        chk("r_rise_miss", spi_data_len != 0, 1);
      end
      if (!busy) chk("r_idle_len", spi_data_len, 0);
      chk("r_err", err_timeout, 0);

      p_busy = busy; p_sdl = spi_data_len;
      act_cnt = (spi_data_len != 0) ? act_cnt + 1 : 0;
      if (spi_data_len != 0) done = (act_cnt >= 4) || ($urandom % 4 == 0);
      else                   done = ($urandom % 16 == 0);
      enable       = ($urandom % 8 != 0);
      clear_status = ($urandom % 50 == 0);
      cmd_count    = CW'($urandom_range(0, 9));
      read_space   = CW'($urandom_range(0, 9));
      if (fifo.size() < 3 && $urandom % 5 == 0) fifo.push_back(rand_desc());
      upd_fifo();
      p_done = done; p_clr = clear_status; p_en = enable; p_empty = desc_empty;

      // a popped descriptor issues 2 cycles after the first cycle its buffer suffices
      if (chk_on) begin
        words = (int'(chk_d[7:0]) + 31) / 32;
        if (chk_d[7:0] == 8'd0) begin
          chk_on = 0; zero_at = c + 1;
        end else if ((chk_d[31] ? int'(cmd_count) : int'(read_space)) >= words) begin
          chk_on = 0; exp_rise = c + 2; iss_d = chk_d;
        end
      end
    end

    done = 0; clear_status = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
